// File: rtl/vled_demo.sv
// vled_demo: LED burst blinker, BLINK_COUNT blinks of ON/OFF cycles followed by a dark pause
module vled_demo #(
    parameter int unsigned ON_CYCLES    = 8,
    parameter int unsigned OFF_CYCLES   = 8,
    parameter int unsigned BLINK_COUNT  = 3,
    parameter int unsigned PAUSE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic led
);
    localparam int unsigned MAX_ON_OFF = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MAX_CYCLES = MAX_ON_OFF > PAUSE_CYCLES ? MAX_ON_OFF : PAUSE_CYCLES;
    localparam int unsigned TW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned BW = BLINK_COUNT > 1 ? $clog2(BLINK_COUNT) : 1;
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BLINK_COUNT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, PAUSE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] burst_q, burst_d;

    // state, phase timer and burst counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            burst_q <= burst_d;
        end
    end

    // next-state logic: the timer counts within a phase and clears on every transition
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                state_d = ON;
                timer_d = '0;
            end
            ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = OFF;
                    timer_d = '0;
                end
            end
            OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (burst_q == BURST_LAST) begin
                        state_d = PAUSE;
                        burst_d = '0;
                    end else begin
                        state_d = ON;
                        burst_d = burst_q + BW'(1);
                    end
                end
            end
            PAUSE: begin
                if (timer_q == PAUSE_LAST) begin
                    state_d = ON;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                burst_d = '0;
            end
        endcase
    end

    assign led = (state_q == ON);
endmodule

// File: tb/tb_vled_demo.sv
// tb_vled_demo: scoreboard bench for vled_demo with default and minimal parameter sets
module tb_vled_demo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led_def, led_min;
    int passed = 0;
    int total = 0;
    int k = 0;
    bit exp_def_q[$];
    bit exp_min_q[$];

    always #5 clk = ~clk;

    vled_demo u_def (.clk(clk), .rst_n(rst_n), .led(led_def));

    vled_demo #(
        .ON_CYCLES(1), .OFF_CYCLES(1), .BLINK_COUNT(1), .PAUSE_CYCLES(1)
    ) u_min (.clk(clk), .rst_n(rst_n), .led(led_min));

    // expected led after k rising edges sampled with reset released
    function automatic bit model(int kk, int on, int off, int bc, int pause);
        int p;
        if (kk == 0) return 1'b0;
        p = (kk - 1) % (bc * (on + off) + pause);
        return (p < bc * (on + off)) && ((p % (on + off)) < on);
    endfunction

    // one clock: count the edge, change reset off-edge, then queue expectations
    task automatic step(input bit rst_next);
        @(posedge clk);
        if (rst_n) k++;
        #3;
        rst_n = rst_next;
        if (!rst_n) k = 0;
        #1;
        exp_def_q.push_back(rst_n ? model(k, 8, 8, 3, 16) : 1'b0);
        exp_min_q.push_back(rst_n ? model(k, 1, 1, 1, 1) : 1'b0);
    endtask

    // monitor: compare the led outputs against queued expectations on the falling edge
    always @(negedge clk) begin
        bit e;
        if (exp_def_q.size() > 0) begin
            e = exp_def_q.pop_front();
            total++;
            if (led_def === e) passed++;
            else $display("FAIL led_def t=%0t got=%b exp=%b", $time, led_def, e);
        end
        if (exp_min_q.size() > 0) begin
            e = exp_min_q.pop_front();
            total++;
            if (led_min === e) passed++;
            else $display("FAIL led_min t=%0t got=%b exp=%b", $time, led_min, e);
        end
    end

    initial begin
        repeat (10) step(1'b0);
        repeat (130) step(1'b1);
        repeat (8) step(1'b1);
        repeat (3) step(1'b0);
        repeat (100) step(1'b1);
        for (int i = 0; i < 600; i++) step($urandom_range(0, 59) != 0);
        repeat (4) step(1'b1);
        repeat (50) begin
            if (exp_def_q.size() == 0 && exp_min_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_def_q.size() != 0 || exp_min_q.size() != 0) begin
            total++;
            $display("FAIL drain left=%0d required=0", exp_def_q.size() + exp_min_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
